// File: rtl/score_track_pkg.sv
// rtl/score_track_pkg.sv - shared state encoding, defaults and ID layout helper for the score tracker
package score_track_pkg;

  localparam int DEF_NUM_PLAYERS = 8;
  localparam int DEF_SCORE_W     = 7;

  localparam logic [2:0] S_CLEAR = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_RD    = 3'd2;
  localparam logic [2:0] S_CMP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  typedef enum logic [2:0] {
    ST_CLEAR = S_CLEAR,
    ST_IDLE  = S_IDLE,
    ST_RD    = S_RD,
    ST_CMP   = S_CMP,
    ST_DONE  = S_DONE
  } state_e;

  // The guest flag sits directly above the player index in the winner ID.
  function automatic int guest_bit_pos(input int id_w);
    return id_w;
  endfunction

endpackage

// File: rtl/score_ram.sv
// rtl/score_ram.sv - single-port score table, synchronous write, registered read, no reset
module score_ram #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = 7
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/score_tracker_param.sv
// rtl/score_tracker_param.sv - personal-best table plus running global winner behind a ready/valid request port
module score_tracker_param
  import score_track_pkg::*;
#(
  parameter int NUM_PLAYERS = DEF_NUM_PLAYERS,
  parameter int ID_W        = 3,
  parameter int SCORE_W     = DEF_SCORE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               score_req,
  input  logic               clear_req,
  input  logic [ID_W-1:0]    player_id,
  input  logic               is_guest,
  input  logic [SCORE_W-1:0] score,
  output logic               ready,
  output logic               valid,
  output logic               err,
  output logic               personal_best,
  output logic [SCORE_W-1:0] prev_best,
  output logic               global_winner,
  output logic               winner_valid,
  output logic [ID_W:0]      global_winner_id,
  output logic [SCORE_W-1:0] global_winner_score
);

  localparam int GUEST_BIT = guest_bit_pos(ID_W);
  localparam logic [ID_W-1:0] LAST_ADDR = ID_W'(NUM_PLAYERS - 1);

  state_e state_q, state_d;
  logic [ID_W-1:0]    clr_addr_q, clr_addr_d;
  logic [ID_W-1:0]    lat_id_q;
  logic               lat_guest_q;
  logic [SCORE_W-1:0] lat_score_q;
  logic               valid_q, err_q, pb_q, gw_q;
  logic [SCORE_W-1:0] prev_q;
  logic               win_valid_q;
  logic [ID_W:0]      win_id_q;
  logic [SCORE_W-1:0] win_score_q;

  logic               ram_we, ram_re;
  logic [ID_W-1:0]    ram_addr;
  logic [SCORE_W-1:0] ram_wdata, ram_rdata;
  logic               lat_err, pb_w, gw_w, accept, clear_go;
  logic [SCORE_W-1:0] prev_w;
  logic [ID_W:0]      req_wid;

  score_ram #(.DEPTH(NUM_PLAYERS), .AW(ID_W), .DW(SCORE_W)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // Guests and out-of-range IDs never touch the table, so the read data is ignored for them.
  assign lat_err  = !lat_guest_q && (32'(lat_id_q) >= NUM_PLAYERS);
  assign pb_w     = !lat_guest_q && !lat_err && (lat_score_q > ram_rdata);
  assign prev_w   = (lat_guest_q || lat_err) ? '0 : ram_rdata;
  assign gw_w     = !lat_err && (lat_score_q > win_score_q);
  assign accept   = ready && score_req && !clear_req;
  assign clear_go = ready && clear_req;

  always_comb begin
    req_wid = '0;
    req_wid[GUEST_BIT] = lat_guest_q;
    req_wid[ID_W-1:0]  = lat_id_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    ready      = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_addr   = lat_id_q;
    ram_wdata  = lat_score_q;
    case (state_q)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_addr  = clr_addr_q;
        ram_wdata = '0;
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = ST_IDLE;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      ST_IDLE: begin
        ready = 1'b1;
        if (clear_req) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end else if (score_req) begin
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        ram_re  = !lat_guest_q && !lat_err;
        state_d = ST_CMP;
      end
      ST_CMP: begin
        ram_we  = pb_w;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_id_q    <= '0;
      lat_guest_q <= 1'b0;
      lat_score_q <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      pb_q        <= 1'b0;
      prev_q      <= '0;
      gw_q        <= 1'b0;
      win_valid_q <= 1'b0;
      win_id_q    <= '0;
      win_score_q <= '0;
    end else begin
      valid_q <= 1'b0;
      if (accept) begin
        lat_id_q    <= player_id;
        lat_guest_q <= is_guest;
        lat_score_q <= score;
      end
      if (clear_go) begin
        win_valid_q <= 1'b0;
        win_id_q    <= '0;
        win_score_q <= '0;
      end
      if (state_q == ST_CMP) begin
        valid_q <= 1'b1;
        err_q   <= lat_err;
        pb_q    <= pb_w;
        prev_q  <= prev_w;
        gw_q    <= gw_w;
        if (gw_w) begin
          win_valid_q <= 1'b1;
          win_id_q    <= req_wid;
          win_score_q <= lat_score_q;
        end
      end
    end
  end

  assign valid               = valid_q;
  assign err                 = err_q;
  assign personal_best       = pb_q;
  assign prev_best           = prev_q;
  assign global_winner       = gw_q;
  assign winner_valid        = win_valid_q;
  assign global_winner_id    = win_id_q;
  assign global_winner_score = win_score_q;

endmodule
